// File: rtl/ysyx_23060077_if_id_buf_pkg.sv
// Shared defaults and types for the IF/ID instruction buffer.
// Imported by ysyx_23060077_if_id_buf.
package ysyx_23060077_if_id_buf_pkg;

  localparam int IFID_DEPTH      = 2;
  localparam int IFID_INST_WIDTH = 32;

  // Per-cycle FIFO operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/ysyx_23060077_if_id_buf.sv
// IF/ID decoupling buffer: circular FIFO of (pc, inst) pairs with flush.
// Optional zero-latency bypass when empty is enabled by defining IFID_BYPASS_EN.
module ysyx_23060077_if_id_buf
  import ysyx_23060077_if_id_buf_pkg::*;
#(
  parameter  int DEPTH      = IFID_DEPTH,
  parameter  int INST_WIDTH = IFID_INST_WIDTH,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic [INST_WIDTH-1:0] if_pc_i,
  input  logic [INST_WIDTH-1:0] if_inst_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [INST_WIDTH-1:0] id_pc_o,
  output logic [INST_WIDTH-1:0] id_inst_o,
  output logic [PTR_W:0]        count_o
);

  typedef struct packed {
    logic [INST_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic     empty;
  logic     full;
  logic     bypass_vld;
  logic     bypass_take;
  logic     push;
  logic     pop;
  fifo_op_e op;
  entry_t   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign head  = mem_q[rd_ptr_q];

`ifdef IFID_BYPASS_EN
  assign bypass_vld  = empty && if_valid_i && !flush_i;
  assign bypass_take = bypass_vld && id_ready_i;
`else
  assign bypass_vld  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Ready depends only on occupancy, never on id_ready_i: no push while full.
  assign if_ready_o = !full;
  assign push       = if_valid_i && !full && !bypass_take;
  assign pop        = !empty && id_ready_i;
  assign op         = fifo_op_e'({push, pop});

  always_comb begin
    id_valid_o = !empty;
    id_pc_o    = head.pc;
    id_inst_o  = head.inst;
    if (bypass_vld) begin
      id_valid_o = 1'b1;
      id_pc_o    = if_pc_i;
      id_inst_o  = if_inst_i;
    end
  end

  assign count_o = count_q;

  // NOTE: every next-state variable is given its hold value first so no path
  // leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;

    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{pc: if_pc_i, inst: if_inst_i};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case (op)
        OP_PUSH: count_d = count_q + (PTR_W+1)'(1);
        OP_POP:  count_d = count_q - (PTR_W+1)'(1);
        OP_BOTH: count_d = count_q;
        OP_IDLE: count_d = count_q;
      endcase
    end
  end

  // NOTE: the storage array is reset along with the pointers so that the
  // head outputs read a defined zero after reset rather than X.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_if_id_buf.sv
// Scoreboard bench for ysyx_23060077_if_id_buf: stimulus queues expected pairs,
// a monitor pops and compares on each accepted output handshake.
module tb_ysyx_23060077_if_id_buf;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] if_pc_i;
  logic [31:0] if_inst_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic [1:0]  count_o;

  ysyx_23060077_if_id_buf dut (
    .clock      (clock),
    .reset      (reset),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_ready_o (if_ready_o),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .id_valid_o (id_valid_o),
    .id_ready_i (id_ready_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .count_o    (count_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: a pop happens at the next edge when id_valid_o && id_ready_i.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset && !flush_i && id_valid_o && id_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc 0x%08h with empty scoreboard at %0t", id_pc_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", id_pc_o, e.pc);
          check("pop_inst", id_inst_o, e.inst);
        end
        n_popped++;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_pair(input logic [31:0] pc, input logic [31:0] inst);
    bit done;
    done       = 1'b0;
    if_valid_i = 1'b1;
    if_pc_i    = pc;
    if_inst_i  = inst;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clock);
      if (if_ready_o && !flush_i) begin
        exp_q.push_back('{pc: pc, inst: inst});
        done = 1'b1;
      end
      step();
    end
    if_valid_i = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: pc 0x%08h never accepted", pc);
    end
  endtask

  initial begin
    int start_pop;
    reset      = 1'b1;
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    id_ready_i = 1'b0;
    if_pc_i    = '0;
    if_inst_i  = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_valid", id_valid_o, 0);
    check("rst_ready", if_ready_o, 1);
    check("rst_count", count_o, 0);
    check("rst_pc", id_pc_o, 0);
    check("rst_inst", id_inst_o, 0);
    step();

    // T1: single push with consumer ready
    id_ready_i = 1'b1;
    if_valid_i = 1'b1;
    if_pc_i    = 32'h3000_0000;
    if_inst_i  = 32'h0000_0413;
    @(negedge clock);
    check("t1_cnt0", count_o, 0);
    check("t1_ready", if_ready_o, 1);
`ifdef IFID_BYPASS_EN
    check("t1_same_cycle_valid", id_valid_o, 1);
`else
    check("t1_same_cycle_valid", id_valid_o, 0);
`endif
    exp_q.push_back('{pc: 32'h3000_0000, inst: 32'h0000_0413});
    step();
    if_valid_i = 1'b0;
    @(negedge clock);
`ifdef IFID_BYPASS_EN
    check("t1_cnt1", count_o, 0);
    check("t1_valid1", id_valid_o, 0);
`else
    check("t1_cnt1", count_o, 1);
    check("t1_valid1", id_valid_o, 1);
`endif
    step();
    @(negedge clock);
    check("t1_cnt2", count_o, 0);
    check("t1_valid2", id_valid_o, 0);
    step();

    // T2: fill with consumer stalled, then drain in order
    id_ready_i = 1'b0;
    push_pair(32'h3000_0000, 32'h0000_0413);
    push_pair(32'h3000_0004, 32'h0044_0413);
    @(negedge clock);
    check("t2_full_ready", if_ready_o, 0);
    check("t2_full_cnt", count_o, 2);
    check("t2_full_valid", id_valid_o, 1);
    step();
    id_ready_i = 1'b1;
    step();
    step();
    @(negedge clock);
    check("t2_drained_cnt", count_o, 0);
    check("t2_drained_q", exp_q.size(), 0);
    step();

    // T3: full, push and pop presented together
    id_ready_i = 1'b0;
    push_pair(32'h3000_0008, 32'h0000_0093);
    push_pair(32'h3000_000C, 32'h0010_0093);
    id_ready_i = 1'b1;
    if_valid_i = 1'b1;
    if_pc_i    = 32'h3000_0010;
    if_inst_i  = 32'h0020_0093;
    @(negedge clock);
    check("t3_full_noready", if_ready_o, 0);
    check("t3_full_cnt", count_o, 2);
    step();
    @(negedge clock);
    check("t3_after_pop_cnt", count_o, 1);
    check("t3_after_pop_ready", if_ready_o, 1);
    exp_q.push_back('{pc: 32'h3000_0010, inst: 32'h0020_0093});
    step();
    if_valid_i = 1'b0;
    @(negedge clock);
    check("t3_both_cnt", count_o, 1);
    step();
    @(negedge clock);
    check("t3_empty_cnt", count_o, 0);
    step();

    // T4: flush with two entries and a push in the same cycle
    id_ready_i = 1'b0;
    push_pair(32'h3000_0020, 32'h0000_0113);
    push_pair(32'h3000_0024, 32'h0010_0113);
    flush_i    = 1'b1;
    if_valid_i = 1'b1;
    if_pc_i    = 32'h3000_0100;
    if_inst_i  = 32'h0000_0213;
    @(negedge clock);
    check("t4_pre_cnt", count_o, 2);
    exp_q.delete();
    step();
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    @(negedge clock);
    check("t4_cnt", count_o, 0);
    check("t4_valid", id_valid_o, 0);
    check("t4_ready", if_ready_o, 1);
    step();

    // T4b: flush with one entry; push accepted by ready and a pop both dropped
    push_pair(32'h3000_0030, 32'h0000_0313);
    flush_i    = 1'b1;
    if_valid_i = 1'b1;
    id_ready_i = 1'b1;
    if_pc_i    = 32'h3000_0200;
    if_inst_i  = 32'h0000_0413;
    @(negedge clock);
    check("t4b_ready", if_ready_o, 1);
    exp_q.delete();
    step();
    flush_i    = 1'b0;
    if_valid_i = 1'b0;
    @(negedge clock);
    check("t4b_cnt", count_o, 0);
    check("t4b_valid", id_valid_o, 0);
    repeat (3) step();
    @(negedge clock);
    check("t4b_idle_cnt", count_o, 0);
    step();

    // T5: streaming 16 pcs with a randomly stalling consumer
    start_pop = n_popped;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          push_pair(32'h3000_1000 + 32'(i * 4), 32'h0000_0013 | 32'(i << 7));
        end
      end
      begin
        for (int c = 0; c < 600 && (n_popped - start_pop) < 16; c++) begin
          id_ready_i = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    id_ready_i = 1'b1;
    repeat (4) step();
    @(negedge clock);
    check("t5_cnt", count_o, 0);
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_pops", 32'(n_popped - start_pop), 16);
    step();

    // T6: push into empty buffer with consumer ready
    id_ready_i = 1'b1;
    if_valid_i = 1'b1;
    if_pc_i    = 32'h8000_0000;
    if_inst_i  = 32'h0000_0073;
    @(negedge clock);
`ifdef IFID_BYPASS_EN
    check("t6_byp_valid", id_valid_o, 1);
    check("t6_byp_pc", id_pc_o, 32'h8000_0000);
`else
    check("t6_valid", id_valid_o, 0);
`endif
    check("t6_cnt0", count_o, 0);
    exp_q.push_back('{pc: 32'h8000_0000, inst: 32'h0000_0073});
    step();
    if_valid_i = 1'b0;
    @(negedge clock);
`ifdef IFID_BYPASS_EN
    check("t6_cnt1", count_o, 0);
`else
    check("t6_cnt1", count_o, 1);
    check("t6_valid1", id_valid_o, 1);
`endif
    step();

    // Reset in mid-operation discards entries
    id_ready_i = 1'b0;
    push_pair(32'h3000_0040, 32'h0000_0513);
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("rst2_cnt", count_o, 0);
    check("rst2_valid", id_valid_o, 0);
    check("rst2_pc", id_pc_o, 0);
    step();

    repeat (2) step();
    check("final_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
